input_buffer_fifo: RTL and testbench
====================================

// Module: input_buffer_fifo
// PURPOSE
//  Parametrised successor input buffer: a circular FIFO of N-lane trace vectors at the
//  front of the debug chain, between the traced datapath and the filter/reduce stages.
//  Adds exact occupancy tracking, consumer-driven dequeue, EOF stored per entry,
//  configurable overflow policy (block or drop-oldest) and a sticky overflow flag.
// PARAMETERS
//  N            8    vector lanes
//  DATA_WIDTH   32   bits per lane
//  IB_DEPTH     4    entries; any value >=2 (not restricted to powers of two)
//  LATENCY      2    dequeue-to-valid_out latency in cycles (RAM read 1 + output reg 1)
//  CONFIG_ID    0    configId value addressing this block
// PORTS
//  clk          in   1                   clock
//  reset        in   1                   synchronous, active-high reset
//  enqueue      in   1                   push vector_in/eof_in this cycle
//  eof_in       in   1                   end-of-frame marker for pushed vector
//  tracing      in   1                   pushes ignored when 0
//  configId     in   8                   config address
//  configData   in   8                   config payload
//  vector_in    in   DATA_WIDTH x N      input vector
//  dequeue      in   1                   consumer requests one entry
//  valid_out    out  1                   vector_out/eof_out valid this cycle
//  eof_out      out  1                   EOF bit of the popped entry
//  vector_out   out  DATA_WIDTH x N      popped vector
//  chainId_out  out  1                   constant 0
//  full         out  1                   count==IB_DEPTH
//  empty        out  1                   count==0
//  occupancy    out  $clog2(IB_DEPTH+1)  entries held
//  overflow     out  1                   sticky: a push was dropped or overwrote data
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Reset: wr_ptr=rd_ptr=0, count=0,
//    mode=BLOCK, overflow=0, valid_out=0, eof_out=0, vector_out=0, read pipeline
//    valid bits cleared (in-flight reads discarded). RAM contents not cleared.
//  - push_req = enqueue & tracing. pop = dequeue & ~empty. dequeue while empty ignored.
//  - Memory word = {eof, vector}, width N*DATA_WIDTH+1; eof travels with its vector.
//  - BLOCK mode: push accepted iff ~full | pop. Rejected push sets overflow.
//  - DROP_OLDEST mode, full & ~pop: push overwrites oldest, rd_ptr advances, count
//    unchanged, overflow set. Full & pop: normal push+pop.
//  - Push+pop same cycle: count unchanged. Push to empty: readable next cycle (no bypass).
//  - Pointers wrap IB_DEPTH-1 -> 0 explicitly (compare, not modulo power of two).
//  - full/empty/occupancy derive from registered count, update cycle after push/pop.
//  - Pop at cycle t -> valid_out=1 with that entry at t+LATENCY; one-cycle pulse per pop;
//    back-to-back pops give back-to-back valid cycles. When valid_out=0, vector_out
//    and eof_out hold last value.
//  - Config: configId==CONFIG_ID latches configData[0] as mode (0 BLOCK, 1 DROP_OLDEST);
//    configData[1]=1 clears overflow that cycle (a simultaneous overflow event wins).
// STRUCTURE
//  - Shared package: ib_mode_t enum {IB_BLOCK, IB_DROP_OLDEST}, config bit indices.
//  - Sub-module: reuse ram_dual_port (port A write, port B read, latency 1).
//  - Pointer/count controller kept inline; output register stage inline.
// TESTING
//  - Reset, push 3 vectors (lane0=1,2,3), eof on 3rd; pop 3 -> valid_out at t+2 each,
//    lane0 1,2,3, eof_out only on 3rd; empty=1 after.
//  - BLOCK, IB_DEPTH=4: push 5 without pop -> full=1, occupancy=4, overflow=1; pops
//    return 1..4.
//  - DROP_OLDEST: push 1..6 into depth 4 -> pops return 3,4,5,6; overflow=1.
//  - Full, simultaneous push 9 + pop -> occupancy stays 4, no overflow, 9 read last.
//  - tracing=0 pushes ignored; dequeue while empty -> no valid_out; IB_DEPTH=3 wraps.
//  - reset asserted 1 cycle after pop -> no valid_out, occupancy=0; config clear
//    drops overflow to 0.

Source files
------------

// File: rtl/input_buffer_fifo_pkg.sv
// Shared definitions for the debug-chain input buffer.
//  - ib_mode_t      : overflow policy selected through the config bus
//  - CFG_*_BIT      : bit positions inside configData
package input_buffer_fifo_pkg;

  typedef enum logic {
    IB_BLOCK       = 1'b0,  // reject pushes while full
    IB_DROP_OLDEST = 1'b1   // overwrite the oldest entry while full
  } ib_mode_t;

  localparam int CFG_MODE_BIT    = 0;  // configData bit latched as ib_mode_t
  localparam int CFG_CLR_OVF_BIT = 1;  // configData bit that clears the sticky overflow

endpackage

// File: rtl/ram_dual_port.sv
// Simple dual-port RAM: port A writes, port B reads with one cycle of latency.
//  clk     in   clock
//  we_a    in   write enable, port A
//  addr_a  in   write address
//  din_a   in   write data
//  addr_b  in   read address
//  dout_b  out  registered read data, mem[addr_b] from the previous edge
module ram_dual_port #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [WIDTH-1:0] din_a,
  input  logic [AW-1:0]    addr_b,
  output logic [WIDTH-1:0] dout_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; readers must never
  // rely on contents that were not written first.
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    // Read-before-write: a same-address write in this cycle is not visible
    // until the next read, which the FIFO relies on for full push+pop.
    dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/input_buffer_fifo.sv
// Circular input buffer at the front of the debug chain. Stores N-lane trace
// vectors with their EOF bit, tracks exact occupancy, and hands entries to the
// consumer on dequeue with a fixed LATENCY-cycle read pipeline.
//  clk, reset           clock; synchronous active-high reset
//  enqueue/eof_in/
//  vector_in/tracing    push side; pushes are ignored while tracing is 0
//  configId/configData  config bus: mode bit and overflow-clear bit
//  dequeue              consumer pop request (ignored while empty)
//  valid_out/eof_out/
//  vector_out           popped entry, one pulse per pop; data holds otherwise
//  chainId_out          constant 0
//  full/empty/occupancy registered fill state
//  overflow             sticky: a push was rejected or overwrote the oldest entry
module input_buffer_fifo
  import input_buffer_fifo_pkg::*;
#(
  parameter  int N          = 8,
  parameter  int DATA_WIDTH = 32,
  parameter  int IB_DEPTH   = 4,
  parameter  int LATENCY    = 2,   // RAM read (1) + LATENCY-1 output stages; >= 2
  parameter  int CONFIG_ID  = 0,
  localparam int OCC_W      = $clog2(IB_DEPTH + 1),
  localparam int PTR_W      = $clog2(IB_DEPTH),
  localparam int WORD_W     = N * DATA_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enqueue,
  input  logic                         eof_in,
  input  logic                         tracing,
  input  logic [7:0]                   configId,
  input  logic [7:0]                   configData,
  input  logic [N-1:0][DATA_WIDTH-1:0] vector_in,
  input  logic                         dequeue,
  output logic                         valid_out,
  output logic                         eof_out,
  output logic [N-1:0][DATA_WIDTH-1:0] vector_out,
  output logic                         chainId_out,
  output logic                         full,
  output logic                         empty,
  output logic [OCC_W-1:0]             occupancy,
  output logic                         overflow
);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  count;
  ib_mode_t          mode;
  logic              overflow_q;

  logic              push_req, pop, cfg_hit;
  logic              push_ok, drop_oldest, ovf_event;
  logic [WORD_W-1:0] ram_rdata;

  // Pointers wrap by compare so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(IB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == OCC_W'(IB_DEPTH));
  assign empty     = (count == '0);
  assign occupancy = count;
  assign overflow  = overflow_q;
  assign chainId_out = 1'b0;

  assign push_req = enqueue & tracing;
  assign pop      = dequeue & ~empty;
  assign cfg_hit  = (configId == 8'(CONFIG_ID));

  // Upper config bits carry no meaning for this block.
  logic unused_cfg;
  assign unused_cfg = ^configData[7:2];

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    push_ok     = 1'b0;
    drop_oldest = 1'b0;
    ovf_event   = 1'b0;
    if (push_req) begin
      if (!full || pop) begin
        push_ok = 1'b1;
      end else if (mode == IB_DROP_OLDEST) begin
        push_ok     = 1'b1;
        drop_oldest = 1'b1;
        ovf_event   = 1'b1;
      end else begin
        ovf_event = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      mode       <= IB_BLOCK;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok)             wr_ptr <= next_ptr(wr_ptr);
      if (pop || drop_oldest)  rd_ptr <= next_ptr(rd_ptr);

      // Overwrite-oldest and push+pop both leave the count unchanged.
      if (push_ok && !pop && !drop_oldest) count <= count + 1'b1;
      else if (pop && !push_ok)            count <= count - 1'b1;

      if (cfg_hit) mode <= ib_mode_t'(configData[CFG_MODE_BIT]);

      // A simultaneous overflow event beats a config clear.
      if (ovf_event)                                 overflow_q <= 1'b1;
      else if (cfg_hit && configData[CFG_CLR_OVF_BIT]) overflow_q <= 1'b0;
    end
  end

  ram_dual_port #(
    .WIDTH (WORD_W),
    .DEPTH (IB_DEPTH)
  ) u_ram (
    .clk    (clk),
    .we_a   (push_ok),
    .addr_a (wr_ptr),
    .din_a  ({eof_in, vector_in}),
    .addr_b (rd_ptr),
    .dout_b (ram_rdata)
  );

  // Read pipeline: vld_q[0] marks ram_rdata valid, vld_q[i] marks stage_q[i-1].
  // The last stage is the output register and holds its value between pops.
  logic [LATENCY-1:0] vld_q;
  logic [WORD_W-1:0]  stage_q [LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int j = 0; j < LATENCY - 1; j++) stage_q[j] <= '0;
    end else begin
      vld_q <= {vld_q[LATENCY-2:0], pop};
      if (vld_q[0]) stage_q[0] <= ram_rdata;
      for (int j = 1; j < LATENCY - 1; j++)
        if (vld_q[j]) stage_q[j] <= stage_q[j-1];
    end
  end

  assign valid_out  = vld_q[LATENCY-1];
  assign eof_out    = stage_q[LATENCY-2][WORD_W-1];
  assign vector_out = stage_q[LATENCY-2][WORD_W-2:0];

endmodule

// File: tb/tb_input_buffer_fifo.sv
// Scoreboard bench for input_buffer_fifo: a depth-4 instance for the main
// scenarios and a depth-3 instance for pointer wrap on a non-power-of-two depth.
module tb_input_buffer_fifo;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int WW = N * DW + 1;

  typedef struct {
    logic [WW-1:0] word;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  exp_t q[$];
  exp_t q3[$];

  // Shared control
  logic       reset   = 1'b1;
  logic       tracing = 1'b1;

  // Depth-4 instance
  logic               enqueue = 1'b0, eof_in = 1'b0, dequeue = 1'b0;
  logic [7:0]         configId = 8'hFF, configData = 8'h00;
  logic [N-1:0][DW-1:0] vector_in = '0;
  logic               valid_out, eof_out, chainId_out, full, empty, overflow;
  logic [N-1:0][DW-1:0] vector_out;
  logic [2:0]         occupancy;

  // Depth-3 instance
  logic               enqueue3 = 1'b0, eof_in3 = 1'b0, dequeue3 = 1'b0;
  logic [N-1:0][DW-1:0] vector_in3 = '0;
  logic               valid_out3, eof_out3, chainId_out3, full3, empty3, overflow3;
  logic [N-1:0][DW-1:0] vector_out3;
  logic [1:0]         occupancy3;

  input_buffer_fifo #(.N(N), .DATA_WIDTH(DW), .IB_DEPTH(4), .LATENCY(2), .CONFIG_ID(0)) dut (
    .clk(clk), .reset(reset), .enqueue(enqueue), .eof_in(eof_in), .tracing(tracing),
    .configId(configId), .configData(configData), .vector_in(vector_in), .dequeue(dequeue),
    .valid_out(valid_out), .eof_out(eof_out), .vector_out(vector_out),
    .chainId_out(chainId_out), .full(full), .empty(empty), .occupancy(occupancy),
    .overflow(overflow)
  );

  input_buffer_fifo #(.N(N), .DATA_WIDTH(DW), .IB_DEPTH(3), .LATENCY(2), .CONFIG_ID(0)) dut3 (
    .clk(clk), .reset(reset), .enqueue(enqueue3), .eof_in(eof_in3), .tracing(1'b1),
    .configId(8'hFF), .configData(8'h00), .vector_in(vector_in3), .dequeue(dequeue3),
    .valid_out(valid_out3), .eof_out(eof_out3), .vector_out(vector_out3),
    .chainId_out(chainId_out3), .full(full3), .empty(empty3), .occupancy(occupancy3),
    .overflow(overflow3)
  );

  task automatic check(input string name, input logic [299:0] got, input logic [299:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [N-1:0][DW-1:0] vec_of(input int v);
    logic [N-1:0][DW-1:0] r;
    for (int i = 0; i < N; i++) r[i] = {8'(i), 24'(v)};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus. ev < 0 means the dequeue carries no expectation.
  task automatic drive(input bit d3, input bit enq, input int v, input bit eof,
                       input bit deq, input int ev, input bit eeof);
    exp_t e;
    if (!d3) begin
      enqueue = enq; eof_in = eof; vector_in = vec_of(v); dequeue = deq;
    end else begin
      enqueue3 = enq; eof_in3 = eof; vector_in3 = vec_of(v); dequeue3 = deq;
    end
    if (deq && ev >= 0) begin
      e.word = {eeof, vec_of(ev)};
      e.due  = cyc + 2;
      if (!d3) q.push_back(e); else q3.push_back(e);
    end
    tick();
    enqueue = 1'b0; eof_in = 1'b0; dequeue = 1'b0;
    enqueue3 = 1'b0; eof_in3 = 1'b0; dequeue3 = 1'b0;
  endtask

  task automatic push(input int v, input bit eof = 1'b0);
    drive(1'b0, 1'b1, v, eof, 1'b0, -1, 1'b0);
  endtask

  task automatic pop(input int ev, input bit eeof = 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1, ev, eeof);
  endtask

  task automatic cfg(input logic [7:0] id, input logic [7:0] data);
    configId = id; configData = data;
    tick();
    configId = 8'hFF; configData = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitors: every valid_out must match the head of its queue, on its due cycle.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid: got valid_out=1 at cycle %0d expected no output", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pop_data", {eof_out, vector_out}, e.word);
        check("pop_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    if (valid_out3 === 1'b1) begin
      if (q3.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_valid3: got valid_out=1 at cycle %0d expected no output", cyc);
      end else begin
        exp_t e;
        e = q3.pop_front();
        check("pop3_data", {eof_out3, vector_out3}, e.word);
        check("pop3_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

  initial begin
    // Reset state
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_occ", occupancy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_valid", valid_out, 0);
    check("rst_vec", {eof_out, vector_out}, 0);
    check("rst_chain", chainId_out, 0);

    // Three pushes, EOF on the third, then back-to-back pops
    push(1); push(2); push(3, 1'b1);
    check("p3_occ", occupancy, 3);
    check("p3_empty", empty, 0);
    pop(1); pop(2); pop(3, 1'b1);
    idle(4);
    check("p3_drained_empty", empty, 1);
    check("hold_vec", {eof_out, vector_out}, {1'b1, vec_of(3)});

    // BLOCK: fifth push rejected
    for (int v = 1; v <= 5; v++) push(v);
    check("blk_full", full, 1);
    check("blk_occ", occupancy, 4);
    check("blk_ovf", overflow, 1);
    for (int v = 1; v <= 4; v++) pop(v);
    idle(4);
    check("blk_empty", empty, 1);
    cfg(8'h01, 8'h02);
    check("cfg_wrong_id", overflow, 1);
    cfg(8'h00, 8'h02);
    check("cfg_clear", overflow, 0);

    // DROP_OLDEST: 5 and 6 overwrite 1 and 2
    cfg(8'h00, 8'h01);
    for (int v = 1; v <= 6; v++) push(v);
    check("drop_occ", occupancy, 4);
    check("drop_ovf", overflow, 1);
    for (int v = 3; v <= 6; v++) pop(v);
    idle(4);
    cfg(8'h00, 8'h02);
    check("drop_clear", overflow, 0);

    // Full, push 9 with pop in the same cycle
    for (int v = 1; v <= 4; v++) push(v);
    drive(1'b0, 1'b1, 9, 1'b0, 1'b1, 1, 1'b0);
    check("pp_occ", occupancy, 4);
    check("pp_ovf", overflow, 0);
    pop(2); pop(3); pop(4); pop(9);
    idle(4);
    check("pp_empty", empty, 1);

    // Rejected push and config clear in the same cycle: overflow wins
    for (int v = 1; v <= 4; v++) push(v);
    enqueue = 1'b1; vector_in = vec_of(7); configId = 8'h00; configData = 8'h02;
    tick();
    enqueue = 1'b0; configId = 8'hFF; configData = 8'h00;
    check("ovf_wins", overflow, 1);
    cfg(8'h00, 8'h02);
    check("ovf_cleared", overflow, 0);
    for (int v = 1; v <= 4; v++) pop(v);
    idle(4);

    // tracing=0 ignores pushes; dequeue while empty yields nothing
    tracing = 1'b0;
    push(8);
    tracing = 1'b1;
    check("notrace_occ", occupancy, 0);
    pop(-1);
    idle(4);
    check("deq_empty", empty, 1);

    // Reset one cycle after a pop discards the in-flight read
    push(5);
    pop(-1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(4);
    check("rstpop_occ", occupancy, 0);
    check("rstpop_vec", {eof_out, vector_out}, 0);

    // Depth-3 wrap
    for (int v = 1; v <= 3; v++) drive(1'b1, 1'b1, v, 1'b0, 1'b0, -1, 1'b0);
    check("d3_full", full3, 1);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b1, 1, 1'b0);
    drive(1'b1, 1'b1, 4, 1'b1, 1'b0, -1, 1'b0);
    check("d3_occ", occupancy3, 3);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b1, 2, 1'b0);
    drive(1'b1, 1'b1, 5, 1'b0, 1'b1, 3, 1'b0);
    drive(1'b1, 1'b1, 6, 1'b0, 1'b1, 4, 1'b1);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b1, 5, 1'b0);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b1, 6, 1'b0);
    idle(4);
    check("d3_empty", empty3, 1);
    check("d3_ovf", overflow3, 0);

    check("queue_drained", q.size(), 0);
    check("queue3_drained", q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
